// File: rtl/seg_display_capture_pkg.sv
// Shared 7-segment definitions: segment indices, glyph table, digit bundle.
// The display driver encodes from the same table, so encode and decode cannot drift.
package seg_display_capture_pkg;

  localparam int NUM_DIGITS = 4;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam logic [15:0][6:0] GLYPH_TABLE = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C,
    GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4,
    GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  typedef struct packed {
    logic       err;
    logic [3:0] nib;
  } digit_t;

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    return GLYPH_TABLE[n];
  endfunction

  // Binary index of a one-hot enable; only meaningful when the input is one-hot.
  function automatic logic [1:0] onehot_idx(input logic [3:0] p);
    return {p[3] | p[2], p[3] | p[1]};
  endfunction

  function automatic logic is_onehot4(input logic [3:0] p);
    return (p != 4'd0) && ((p & (p - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/seg_display_capture_glyph_decode.sv
// Combinational 7-bit active-high abcdefg pattern to {err, nibble}.
// Unknown patterns decode to nibble 0 with err set.
module seg_glyph_decode
  import seg_display_capture_pkg::*;
(
  input  logic [6:0] pat_i,
  output digit_t     dig_o
);

  always_comb begin
    dig_o.err = 1'b0;
    dig_o.nib = 4'h0;
    unique case (pat_i)
      GLYPH_0: dig_o.nib = 4'h0;
      GLYPH_1: dig_o.nib = 4'h1;
      GLYPH_2: dig_o.nib = 4'h2;
      GLYPH_3: dig_o.nib = 4'h3;
      GLYPH_4: dig_o.nib = 4'h4;
      GLYPH_5: dig_o.nib = 4'h5;
      GLYPH_6: dig_o.nib = 4'h6;
      GLYPH_7: dig_o.nib = 4'h7;
      GLYPH_8: dig_o.nib = 4'h8;
      GLYPH_9: dig_o.nib = 4'h9;
      GLYPH_A: dig_o.nib = 4'hA;
      GLYPH_B: dig_o.nib = 4'hB;
      GLYPH_C: dig_o.nib = 4'hC;
      GLYPH_D: dig_o.nib = 4'hD;
      GLYPH_E: dig_o.nib = 4'hE;
      GLYPH_F: dig_o.nib = 4'hF;
      default: dig_o.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_display_capture.sv
// Samples multiplexed 7-segment lines, debounces each scanned digit and
// reassembles the displayed 16-bit value with frame/change/stale reporting.
module seg_display_capture
  import seg_display_capture_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter bit ACTIVE_LOW     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segs_in,
  input  logic [3:0]  pos_in,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        value_changed,
  output logic        stale
);

  localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] S_PRE = SW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [6:0]  seg_s1_q, seg_s2_q;
  logic [3:0]  pos_s1_q, pos_s2_q;
  logic [10:0] prev_q, samp;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  digit_t [NUM_DIGITS-1:0] stage_q, stage_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  err_q, err_d;
  logic        fv_q, fv_d;
  logic        vc_q, vc_d;
  logic        stale_q, stale_d;
  logic        first_q, first_d;

  logic [6:0]  segs;
  logic [3:0]  pos;
  logic        pos_ok, same, accept, done;
  logic [1:0]  idx;
  digit_t      dec;

  assign segs = ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
  assign pos  = ACTIVE_LOW ? ~pos_s2_q : pos_s2_q;
  assign samp = {pos, segs};

  assign pos_ok = is_onehot4(pos);
  assign same   = (samp == prev_q);
  assign idx    = onehot_idx(pos);
  // Fires once per stable run: the edge where the counter steps onto its max.
  assign accept = pos_ok && same && (scnt_q == S_PRE);
  assign done   = (mask_q == 4'hF);

  seg_glyph_decode u_dec (
    .pat_i (segs),
    .dig_o (dec)
  );

  always_comb begin
    scnt_d = '0;
    if (pos_ok && same) begin
      scnt_d = (scnt_q == S_MAX) ? scnt_q : scnt_q + SW'(1);
    end
  end

  always_comb begin
    stage_d = stage_q;
    mask_d  = done ? '0 : mask_q;
    value_d = value_q;
    err_d   = err_q;
    fv_d    = 1'b0;
    vc_d    = 1'b0;
    first_d = first_q;
    if (accept) begin
      stage_d[idx] = dec;
      mask_d[idx]  = 1'b1;
    end
    if (done) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        value_d[4*i +: 4] = stage_q[i].nib;
        err_d[i]          = stage_q[i].err;
      end
      fv_d    = 1'b1;
      vc_d    = first_q || (value_d != value_q);
      first_d = 1'b0;
    end
  end

  always_comb begin
    tcnt_d  = tcnt_q;
    stale_d = stale_q;
    if (done) begin
      tcnt_d  = '0;
      stale_d = 1'b0;
    end else if (tcnt_q == T_MAX) begin
      stale_d = 1'b1;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      pos_s1_q <= '0;
      pos_s2_q <= '0;
      prev_q   <= '0;
      scnt_q   <= '0;
      tcnt_q   <= '0;
      stage_q  <= '0;
      mask_q   <= '0;
      value_q  <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      vc_q     <= 1'b0;
      stale_q  <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      seg_s1_q <= segs_in;
      seg_s2_q <= seg_s1_q;
      pos_s1_q <= pos_in;
      pos_s2_q <= pos_s1_q;
      prev_q   <= samp;
      scnt_q   <= scnt_d;
      tcnt_q   <= tcnt_d;
      stage_q  <= stage_d;
      mask_q   <= mask_d;
      value_q  <= value_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      vc_q     <= vc_d;
      stale_q  <= stale_d;
      first_q  <= first_d;
    end
  end

  assign value         = value_q;
  assign digit_err     = err_q;
  assign frame_valid   = fv_q;
  assign value_changed = vc_q;
  assign stale         = stale_q;

endmodule

// File: tb/tb_seg_display_capture.sv
// Directed scan sequences for seg_display_capture with a frame scoreboard.
// Expected frames are queued as scans are driven and popped on frame_valid.
module tb_seg_display_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  segs_in;
  logic [3:0]  pos_in;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        value_changed;
  logic        stale;

  seg_display_capture #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (64),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .segs_in       (segs_in),
    .pos_in        (pos_in),
    .value         (value),
    .digit_err     (digit_err),
    .frame_valid   (frame_valid),
    .value_changed (value_changed),
    .stale         (stale)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  e;
    logic        ch;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int frames = 0;
  int cyc = 0;
  int last_fv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && frame_valid) begin
      exp_t e;
      frames++;
      last_fv = cyc;
      chk("frame_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("value", 32'(value), 32'(e.v));
        chk("digit_err", 32'(digit_err), 32'(e.e));
        chk("value_changed", 32'(value_changed), 32'(e.ch));
        chk("stale_at_frame", 32'(stale), 32'd0);
      end
    end
  end

  task automatic put(input int idx, input logic [6:0] pat, input int n);
    pos_in  = 4'b0001 << idx;
    segs_in = pat;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pos_in  = 4'b0000;
    segs_in = 7'h00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [6:0] p3, input logic [6:0] p2,
                      input logic [6:0] p1, input logic [6:0] p0);
    put(3, p3, 8);
    put(2, p2, 8);
    put(1, p1, 8);
    put(0, p0, 8);
    idle(4);
  endtask

  initial begin
    int f0;
    int wait_n;
    exp_t x;
    rst     = 1'b1;
    segs_in = 7'h00;
    pos_in  = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_digit_err", 32'(digit_err), 32'd0);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_value_changed", 32'(value_changed), 32'd0);
    chk("rst_stale", 32'(stale), 32'd0);
    rst = 1'b0;
    idle(4);

    // first frame 1234
    x = '{v: 16'h1234, e: 4'h0, ch: 1'b1}; sb.push_back(x);
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);

    // identical rescan
    x = '{v: 16'h1234, e: 4'h0, ch: 1'b0}; sb.push_back(x);
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);

    // short glitch to 8 on digit0 must not be taken
    x = '{v: 16'h1234, e: 4'h0, ch: 1'b0}; sb.push_back(x);
    put(3, 7'h06, 8);
    put(2, 7'h5B, 8);
    put(1, 7'h4F, 8);
    put(0, 7'h66, 3);
    put(0, 7'h7F, 2);
    put(0, 7'h66, 8);
    idle(4);

    // illegal enables between partial capture and the last digit
    put(3, 7'h06, 8);
    put(2, 7'h5B, 8);
    put(1, 7'h4F, 8);
    f0 = frames;
    pos_in  = 4'b0110;
    segs_in = 7'h3F;
    repeat (10) @(posedge clk);
    #1;
    idle(10);
    chk("no_frame_bad_pos", 32'(frames), 32'(f0));
    x = '{v: 16'h1234, e: 4'h0, ch: 1'b0}; sb.push_back(x);
    put(0, 7'h66, 8);
    idle(4);
    chk("frame_after_bad_pos", 32'(frames), 32'(f0 + 1));

    // non-glyph on digit1
    x = '{v: 16'h1204, e: 4'b0010, ch: 1'b1}; sb.push_back(x);
    scan(7'h06, 7'h5B, 7'h55, 7'h66);

    x = '{v: 16'h1234, e: 4'h0, ch: 1'b1}; sb.push_back(x);
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);

    // timeout: stale exactly 64 cycles after the last frame
    wait_n = 63 - (cyc - last_fv);
    chk("timeout_window", 32'(wait_n > 0), 32'd1);
    if (wait_n > 0) repeat (wait_n) @(posedge clk);
    #1;
    chk("stale_before_64", 32'(stale), 32'd0);
    @(posedge clk);
    #1;
    chk("stale_at_64", 32'(stale), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("stale_held", 32'(stale), 32'd1);
    chk("value_held_stale", 32'(value), 32'h1234);

    x = '{v: 16'h1234, e: 4'h0, ch: 1'b0}; sb.push_back(x);
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    chk("stale_cleared", 32'(stale), 32'd0);

    // reset mid-frame discards partial staging
    put(3, 7'h7F, 8);
    put(2, 7'h7F, 8);
    rst    = 1'b1;
    pos_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_value", 32'(value), 32'd0);
    f0 = frames;
    x = '{v: 16'hABCD, e: 4'h0, ch: 1'b1}; sb.push_back(x);
    scan(7'h77, 7'h7C, 7'h39, 7'h5E);
    chk("one_frame_after_rst", 32'(frames), 32'(f0 + 1));

    idle(4);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("total_frames", 32'(frames), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_capture.md
Name: seg_display_capture

Overview:
- Reverse of the 7-segment display driver: samples the multiplexed segs/pos lines and decodes each scanned digit back to a hex nibble.
- Reassembles the 16-bit displayed value and reports it with a frame strobe.
- Sits beside the Computer top level, either on-chip as a self-check monitor or in the system testbench as the display-side checker.
- Runs on the fast board clock, independent of the divided CPU clock.

Parameters:
STABLE_CYCLES, 4, consecutive identical synchronized samples required to accept a digit (min 2)
TIMEOUT_CYCLES, 65536, clk cycles without a completed frame before stale asserts
ACTIVE_LOW, 1, 1 = segs and pos lines are active-low (common anode); 0 = active-high

Ports:
clk  input  1  system clock
rst  input  1  reset
segs_in  input  7  segment lines, bit0=a ... bit6=g
pos_in  input  4  digit enables, pos_in[3] = most significant digit
value  output  16  last completed frame, digit3 in [15:12] ... digit0 in [3:0]
digit_err  output  4  per-digit flag: last accepted pattern was not a hex glyph
frame_valid  output  1  one-cycle pulse when value updates
value_changed  output  1  one-cycle pulse coincident with frame_valid when value differs from previous frame
stale  output  1  high when no frame has completed for TIMEOUT_CYCLES

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Values after reset:
  - value=0, digit_err=0, frame_valid=0, value_changed=0, stale=0.
  - Capture mask, stability counter, timeout counter and synchronizers cleared.
  - first_frame flag set.
- Input stage:
  - Two-flop synchronizer on segs_in and pos_in.
  - If ACTIVE_LOW=1, both are inverted after synchronization.
  - All later logic uses these active-high synced samples.
- Position check:
  - pos must be one-hot.
  - Zero or multiple bits set: sample ignored, stability counter cleared, no acceptance.
- Stability:
  - Counter increments (saturating at STABLE_CYCLES-1) while {pos,segs} equals the previous cycle's sample.
  - Counter clears on any change.
  - A digit is accepted exactly once per stable run, in the cycle the counter first reaches STABLE_CYCLES-1.
  - Total latency from pin change to acceptance: 2 + STABLE_CYCLES clk cycles.
- Decode, active-high abcdefg (bit0=a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Any other pattern: nibble=0 and the staging error bit for that position is set.
- Staging:
  - On acceptance, the nibble and error bit go to staging slot index(pos), and the mask bit for that slot is set.
  - Re-accepting an already-captured position overwrites that slot (last wins).
- Frame completion:
  - In the cycle after the mask becomes 4'b1111: value<=staging, digit_err<=staging errors, frame_valid=1, mask cleared.
  - value_changed=1 if the new value differs from the old one, or if first_frame is set; first_frame then clears.
  - Simultaneous acceptance in the completion cycle is applied to the next frame's staging and mask.
- Timeout:
  - Counter increments every cycle and clears on frame_valid.
  - When it reaches TIMEOUT_CYCLES-1, stale sets and the counter holds.
  - stale clears in the same cycle frame_valid pulses.
  - value holds its last frame while stale.
- Reset mid-frame: partial staging is discarded; no frame_valid until 4 fresh acceptances.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - Digit count 4.
  - Segment bit-index constants a..g.
  - The 16-entry glyph table as localparams, shared with the display driver so encode and decode cannot diverge.
- Natural sub-module: seg_glyph_decode, a combinational 7-bit pattern to {err, nibble} decoder.
- The stability counter and frame FSM stay in the top.

Test Plan:
- Scan digits 3,2,1,0 with glyphs 06,5B,4F,66, each held 8 cycles (ACTIVE_LOW=0, STABLE_CYCLES=4) -> value=0x1234, one frame_valid pulse with value_changed=1, digit_err=0.
- Repeat identical scan -> frame_valid pulses, value_changed=0, value stays 0x1234.
- Glitch pos0 pattern to 7F for 2 cycles mid-hold -> not accepted; value[3:0] keeps the stable glyph; total frame still completes.
- Drive pos=4'b0110 for 10 cycles, then pos=0 for 10 cycles -> no acceptance, mask unchanged, no frame_valid.
- Digit1 glyph 0x55 in a full scan -> value[7:4]=0, digit_err=4'b0010 with frame_valid.
- Stop scanning with TIMEOUT_CYCLES=64 -> stale=1 at cycle 64 after last frame_valid; rescanning a full frame clears stale on its frame_valid.
- Assert rst after 2 digits are accepted, then scan a full frame -> exactly one frame_valid, after 4 fresh acceptances.
